// File: rtl/efpga_pwr_seq.sv
// efpga_pwr_seq: counter-timed eFPGA power/isolation/reset sequencer, registered outputs, request-to-power latency 1 cycle.
// No backpressure: software writes a request level and polls status_o. Power-good timeout enabled by EFPGA_PWR_TIMEOUT_EN.
module efpga_pwr_seq #(
  parameter int T_ISO   = 16,
  parameter int T_RST   = 32,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] control_i,
  input  logic [3:0]  reset_type1_i,
  input  logic        pwr_good_i,
  output logic        pwr_en_o,
  output logic        iso_o,
  output logic        efpga_rstn_o,
  output logic [3:0]  efpga_rst_type1_o,
  output logic        if_en_o,
  output logic [31:0] status_o
);

  typedef enum logic [3:0] {
    S_OFF     = 4'd0,
    S_PWR_UP  = 4'd1,
    S_ISO_REL = 4'd2,
    S_RST_REL = 4'd3,
    S_ON      = 4'd4,
    S_RST_SET = 4'd5,
    S_ISO_SET = 4'd6,
    S_PWR_DN  = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  localparam int L_MAX_T   = (T_ISO > T_RST) ? T_ISO : T_RST;
  localparam int L_MAX_ALL = (L_MAX_T > TIMEOUT) ? L_MAX_T : TIMEOUT;
  localparam logic [CNT_W-1:0] L_ISO_LAST = CNT_W'(T_ISO - 1);
  localparam logic [CNT_W-1:0] L_RST_LAST = CNT_W'(T_RST - 1);
  // Counter parks at the longest terminal count so idle states never wrap it.
  localparam logic [CNT_W-1:0] L_CNT_SAT  = CNT_W'(L_MAX_ALL - 1);
`ifdef EFPGA_PWR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] L_TO_LAST  = CNT_W'(TIMEOUT - 1);
`endif

  logic             r_pg_meta;
  logic             r_pg_s;
  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pwr_en;
  logic             r_iso;
  logic             r_on;
  logic [7:0]       r_pups;
  logic             w_req;
  logic             w_busy;
  logic             w_err;
  logic             w_unused_ctl;

  assign w_req = control_i[0];

`ifdef EFPGA_PWR_TIMEOUT_EN
  logic r_clr_d;
  logic w_clr_rise;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_clr_d <= 1'b0;
    end else begin
      r_clr_d <= control_i[1];
    end
  end

  assign w_clr_rise   = control_i[1] & ~r_clr_d;
  assign w_err        = (r_state == S_ERR);
  assign w_unused_ctl = ^control_i[31:2];
`else
  assign w_err        = 1'b0;
  assign w_unused_ctl = ^control_i[31:1];
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pg_meta <= 1'b0;
      r_pg_s    <= 1'b0;
    end else begin
      r_pg_meta <= pwr_good_i;
      r_pg_s    <= r_pg_meta;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_OFF:     if (w_req) w_nxt = S_PWR_UP;
      S_PWR_UP: begin
        if (r_pg_s) w_nxt = S_ISO_REL;
`ifdef EFPGA_PWR_TIMEOUT_EN
        else if (r_cnt == L_TO_LAST) w_nxt = S_ERR;
`endif
      end
      S_ISO_REL: if (r_cnt == L_ISO_LAST) w_nxt = S_RST_REL;
      S_RST_REL: if (r_cnt == L_RST_LAST) w_nxt = S_ON;
      S_ON:      if (!w_req) w_nxt = S_RST_SET;
      S_RST_SET: if (r_cnt == L_RST_LAST) w_nxt = S_ISO_SET;
      S_ISO_SET: if (r_cnt == L_ISO_LAST) w_nxt = S_PWR_DN;
      S_PWR_DN: begin
        if (!r_pg_s) w_nxt = S_OFF;
`ifdef EFPGA_PWR_TIMEOUT_EN
        else if (r_cnt == L_TO_LAST) w_nxt = S_ERR;
`endif
      end
      S_ERR: begin
`ifdef EFPGA_PWR_TIMEOUT_EN
        if (w_clr_rise) w_nxt = S_OFF;
`endif
      end
      default:   w_nxt = S_OFF;
    endcase
  end

  // Outputs decode the next state so they move on the same edge as r_state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= S_OFF;
      r_cnt    <= '0;
      r_pwr_en <= 1'b0;
      r_iso    <= 1'b1;
      r_on     <= 1'b0;
      r_pups   <= 8'h00;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != L_CNT_SAT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_pwr_en <= (w_nxt != S_OFF) && (w_nxt != S_PWR_DN) && (w_nxt != S_ERR);
      r_iso    <= !((w_nxt == S_RST_REL) || (w_nxt == S_ON) || (w_nxt == S_RST_SET));
      r_on     <= (w_nxt == S_ON);
      if ((w_nxt == S_ON) && (r_state != S_ON) && (r_pups != 8'hFF)) begin
        r_pups <= r_pups + 8'd1;
      end
    end
  end

  assign w_busy = (r_state != S_OFF) && (r_state != S_ON) && (r_state != S_ERR);

  assign pwr_en_o          = r_pwr_en;
  assign iso_o             = r_iso;
  assign efpga_rstn_o      = r_on;
  assign if_en_o           = r_on;
  assign efpga_rst_type1_o = r_on ? reset_type1_i : 4'hF;
  assign status_o          = {16'h0000, r_pups, r_pg_s, w_err, r_on, w_busy, r_state};

endmodule

// File: tb/tb_efpga_pwr_seq.sv
// Directed bench for efpga_pwr_seq: expectations queued at stimulus time, popped and asserted as the DUT responds.
module tb_efpga_pwr_seq;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] control_i;
  logic [3:0]  reset_type1_i;
  logic        pwr_good_i;
  logic        pwr_en_o;
  logic        iso_o;
  logic        efpga_rstn_o;
  logic [3:0]  efpga_rst_type1_o;
  logic        if_en_o;
  logic [31:0] status_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] sb_exp[$];
  string       sb_tag[$];

  always #5 HCLK = ~HCLK;

  efpga_pwr_seq dut (
    .HCLK              (HCLK),
    .HRESETn           (HRESETn),
    .control_i         (control_i),
    .reset_type1_i     (reset_type1_i),
    .pwr_good_i        (pwr_good_i),
    .pwr_en_o          (pwr_en_o),
    .iso_o             (iso_o),
    .efpga_rstn_o      (efpga_rstn_o),
    .efpga_rst_type1_o (efpga_rst_type1_o),
    .if_en_o           (if_en_o),
    .status_o          (status_o)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge HCLK);
      #1;
      cyc++;
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] e);
    sb_tag.push_back(tag);
    sb_exp.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_vec++;
    if (sb_exp.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: got %h required nothing queued", obs);
    end else begin
      t = sb_tag.pop_front();
      e = sb_exp.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: got %h required %h", t, obs, e);
      end
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return pwr_en_o;
      1:       return iso_o;
      2:       return efpga_rstn_o;
      3:       return status_o[7];
      default: return 1'bx;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int budget, output int at);
    int k = 0;
    while (sig(sel) !== val && k < budget) begin
      tick();
      k++;
    end
    at = cyc;
    n_vec++;
    assert (sig(sel) === val) else begin
      n_err++;
      $error("FAIL wait_sig%0d timeout: got %b required %b", sel, sig(sel), val);
    end
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, output int at);
    int k = 0;
    while (status_o[3:0] !== st && k < budget) begin
      tick();
      k++;
    end
    at = cyc;
    n_vec++;
    assert (status_o[3:0] === st) else begin
      n_err++;
      $error("FAIL wait_state timeout: got %h required %h", status_o[3:0], st);
    end
  endtask

  initial begin
    int t0, t1, t2, t3;
    HRESETn       = 1'b0;
    control_i     = 32'h0;
    reset_type1_i = 4'h5;
    pwr_good_i    = 1'b0;

    // Reset values
    expect_val("rst_pwr_en", 32'h0);
    expect_val("rst_iso", 32'h1);
    expect_val("rst_rstn", 32'h0);
    expect_val("rst_type1", 32'hF);
    expect_val("rst_if_en", 32'h0);
    expect_val("rst_status", 32'h0);
    tick(3);
    observe(32'(pwr_en_o));
    observe(32'(iso_o));
    observe(32'(efpga_rstn_o));
    observe(32'(efpga_rst_type1_o));
    observe(32'(if_en_o));
    observe(status_o);
    HRESETn = 1'b1;
    tick(2);

    // Power-up
    expect_val("type1_off", 32'hF);
    expect_val("pwr_en_lat", 32'd1);
    expect_val("pg_sync_lat", 32'd2);
    expect_val("iso_rel_entry", 32'd1);
    expect_val("iso_fall", 32'd16);
    expect_val("rstn_rise", 32'd32);
    expect_val("status_on", 32'h0000_01A4);
    expect_val("if_en_on", 32'h1);
    expect_val("type1_on", 32'h5);
    observe(32'(efpga_rst_type1_o));
    control_i = 32'h1;
    t0 = cyc;
    wait_sig(0, 1'b1, 10, t1);
    observe(32'(t1 - t0));
    tick(5);
    pwr_good_i = 1'b1;
    t0 = cyc;
    wait_sig(3, 1'b1, 10, t1);
    observe(32'(t1 - t0));
    wait_state(4'd2, 10, t2);
    observe(32'(t2 - t1));
    wait_sig(1, 1'b0, 40, t3);
    observe(32'(t3 - t2));
    wait_sig(2, 1'b1, 80, t1);
    observe(32'(t1 - t3));
    observe(status_o);
    observe(32'(if_en_o));
    observe(32'(efpga_rst_type1_o));

    // Power-down
    expect_val("rstn_fall_lat", 32'd1);
    expect_val("iso_rise", 32'd32);
    expect_val("pwr_en_fall", 32'd16);
    expect_val("status_off", 32'h0000_0100);
    expect_val("type1_off2", 32'hF);
    control_i = 32'h0;
    t0 = cyc;
    wait_sig(2, 1'b0, 10, t1);
    observe(32'(t1 - t0));
    wait_sig(1, 1'b1, 80, t2);
    observe(32'(t2 - t1));
    wait_sig(0, 1'b0, 40, t3);
    observe(32'(t3 - t2));
    pwr_good_i = 1'b0;
    wait_state(4'd0, 10, t1);
    observe(status_o);
    observe(32'(efpga_rst_type1_o));

    // Request dropped during ISO_REL: sequence still completes, then powers down
    expect_val("status_on2", 32'h0000_02A4);
    expect_val("status_rst_set", 32'h0000_0295);
    control_i = 32'h1;
    wait_sig(0, 1'b1, 10, t1);
    pwr_good_i = 1'b1;
    wait_state(4'd2, 10, t1);
    control_i = 32'h0;
    wait_state(4'd4, 100, t1);
    observe(status_o);
    tick();
    observe(status_o);
    wait_sig(0, 1'b0, 100, t1);
    pwr_good_i = 1'b0;
    wait_state(4'd0, 10, t1);

    // Power-good never arrives
    control_i = 32'h1;
    wait_state(4'd1, 10, t0);
`ifdef EFPGA_PWR_TIMEOUT_EN
    expect_val("err_lat", 32'd4096);
    expect_val("status_err", 32'h0000_0248);
    expect_val("pwr_en_err", 32'h0);
    expect_val("clr_to_off", 32'd0);
    expect_val("req_after_clr", 32'd1);
    wait_state(4'd8, 5000, t1);
    observe(32'(t1 - t0));
    observe(status_o);
    observe(32'(pwr_en_o));
    control_i = 32'h3;
    tick();
    observe(32'(status_o[3:0]));
    tick();
    observe(32'(status_o[3:0]));
    control_i = 32'h1;
`else
    expect_val("hold_pwr_up", 32'd1);
    expect_val("no_err", 32'd0);
    tick(300);
    observe(32'(status_o[3:0]));
    observe(32'(status_o[6]));
`endif

    // Asynchronous reset while powered
    expect_val("arst_pwr_en", 32'h0);
    expect_val("arst_iso", 32'h1);
    expect_val("arst_rstn", 32'h0);
    expect_val("arst_type1", 32'hF);
    expect_val("arst_status", 32'h0);
    #2;
    HRESETn = 1'b0;
    #1;
    observe(32'(pwr_en_o));
    observe(32'(iso_o));
    observe(32'(efpga_rstn_o));
    observe(32'(efpga_rst_type1_o));
    observe(status_o);
    tick(2);
    HRESETn = 1'b1;
    control_i = 32'h0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
